uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// Shares one uart_tx transmitter between NREQ byte producers. Round-robin
// arbitration; latches the winner's byte, pulses tx_start, holds tx_din for
// the whole frame and waits for tx_done_tick before the next grant.
// Sits between producer blocks and uart_tx, on uart_tx's clock.
// PARAMETERS
// NREQ        4       number of requesters (>=2)
// DBIT        8       data bits per frame; must match uart_tx DBIT
// GAP_CYC     0       idle clk cycles after tx_done_tick before next grant
// TIMEOUT_CYC 200000  WAIT-state watchdog limit in clk cycles (macro only)
// localparam IDW = max(1,$clog2(NREQ))
// PORTS
// clk           in   1         system clock, all logic on rising edge
// reset         in   1         synchronous, active-high
// req_valid     in   NREQ      bit i: requester i has a byte pending
// req_data      in   NREQ*DBIT requester i byte at [i*DBIT +: DBIT]
// req_ready     out  NREQ      one-hot 1-cycle accept pulse
// grant_id      out  IDW       index of the last granted requester
// busy          out  1         high from grant until return to IDLE
// tx_start      out  1         1-cycle start pulse to uart_tx
// tx_din        out  DBIT      byte to uart_tx, stable while busy
// tx_done_tick  in   1         frame-complete pulse from uart_tx
// timeout_err   out  1         1-cycle watchdog pulse; tied 0 without macro
// BEHAVIOUR
// - Reset: state=IDLE, req_ready=0, tx_start=0, tx_din=0, grant_id=0,
//   busy=0, timeout_err=0, rr pointer=0, gap/timeout counters=0.
// - All outputs registered. FSM states: IDLE, WAIT, GAP.
// - IDLE: if |req_valid, g = first set bit scanning ptr, ptr+1 .. NREQ-1, 0 ..
//   ptr-1. At that edge: tx_din<=req_data[g], grant_id<=g,
//   req_ready<=onehot(g), tx_start<=1, busy<=1, ptr<=(g==NREQ-1)?0:g+1,
//   state<=WAIT. Latency req_valid -> tx_start/req_ready: 1 cycle.
// - Requester holds valid and data until it sees req_ready; may deassert or
//   present the next byte the cycle after. Valid dropped before grant: no effect.
// - WAIT: tx_start and req_ready return to 0 after one cycle. tx_done_tick is
//   ignored in the cycle tx_start=1. On tx_done_tick, go to GAP_CYC==0 ? IDLE : GAP.
// - GAP: count GAP_CYC cycles, then IDLE; no grants while in GAP.
// - busy falls on the edge entering IDLE. A new grant may be issued in the
//   first IDLE cycle, so req_ready-to-req_ready minimum = frame + GAP_CYC + 2.
// - tx_done_tick in IDLE or GAP is ignored. It never causes a grant.
// - Reset mid-frame: immediate IDLE, no req_ready, ptr=0. uart_tx must share
//   the same reset so no frame is half-sent on release.
// CONFIGURATION
// UART_TX_ARB_TIMEOUT_EN defined: a counter runs in WAIT, cleared on grant.
//   If it reaches TIMEOUT_CYC with no tx_done_tick: timeout_err=1 for one
//   cycle, and the block takes the normal tx_done_tick exit (GAP or IDLE).
//   The pointer already advanced, so the stuck requester loses its turn.
// Undefined: no counter is built, timeout_err is constant 0, and WAIT lasts
//   until tx_done_tick.
// TESTING
// 1 Reset held 3 cycles, random req_valid -> all outputs 0, no req_ready.
// 2 req_valid=4'b0100, byte2=8'hA5 -> next cycle req_ready=4'b0100,
//   tx_start=1, tx_din=8'hA5, grant_id=2; done tick 20 cyc later -> busy=0.
// 3 req_valid=4'b1111 held, done tick per frame -> grant order 0,1,2,3,0;
//   tx_din tracks each byte; exactly one req_ready bit per grant.
// 4 After grant to 2 (ptr=3), req_valid=4'b0011 -> grant 0 (wrap), then 1.
// 5 GAP_CYC=3: done tick at cycle T -> busy=0 at T+4; tx_start no earlier
//   than T+5; done tick during tx_start cycle or GAP is ignored.
// 6 Macro on, TIMEOUT_CYC=50, no done tick -> timeout_err pulse 50 cyc after
//   grant, next requester served; macro off -> busy stays 1. Reset mid-WAIT ->
//   IDLE next cycle, busy=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NREQ byte producers
// Define UART_TX_ARB_TIMEOUT_EN to build the WAIT-state watchdog (timeout_err_o).
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int DBIT        = 8,
  parameter int GAP_CYC     = 0,
  parameter int TIMEOUT_CYC = 200000,
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*DBIT-1:0] req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [IDW-1:0]       grant_id_o,
  output logic                 busy_o,
  output logic                 tx_start_o,
  output logic [DBIT-1:0]      tx_din_o,
  input  logic                 tx_done_tick_i,
  output logic                 timeout_err_o
);
  localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_e;
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, grant_id_q, grant_id_d, gnt_idx, rr_j;
  logic [GCW-1:0] gap_q, gap_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;
  logic tx_start_q, tx_start_d, busy_q, busy_d;
  logic grant, done_ok, timeout_hit;

  if (NREQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NREQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  // Scan downward so the last hit is the first set bit at or after ptr_q.
  always_comb begin
    gnt_idx = '0;
    rr_j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_j = IDW'((int'(ptr_q) + k) % NREQ);
      if (req_valid_i[rr_j]) gnt_idx = rr_j;
    end
  end

  assign grant   = (state_q == IDLE) && |req_valid_i;
  assign done_ok = tx_done_tick_i && !tx_start_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] to_q, to_d;
  logic timeout_q;
  assign timeout_hit = (state_q == WAIT) && !done_ok && (to_q == TCW'(TIMEOUT_CYC - 1));
  assign to_d = grant ? '0 : (state_q == WAIT) ? to_q + 1'b1 : to_q;
  always_ff @(posedge clk_i) begin
    to_q      <= reset_i ? '0 : to_d;
    timeout_q <= reset_i ? 1'b0 : timeout_hit;
  end
  assign timeout_err_o = timeout_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      tx_din_q    <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      tx_din_q    <= tx_din_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    case (state_q)
      IDLE: state_d = grant ? WAIT : IDLE;
      WAIT: begin
        gap_d = '0;
        if (done_ok || timeout_hit) state_d = (GAP_CYC == 0) ? IDLE : GAP;
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (int'(gap_q) >= GAP_CYC - 1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = grant ? NREQ'(1) << gnt_idx : '0;
    tx_start_d  = grant;
    tx_din_d    = grant ? req_data_i[int'(gnt_idx)*DBIT +: DBIT] : tx_din_q;
    grant_id_d  = grant ? gnt_idx : grant_id_q;
    ptr_d       = grant ? ((int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    busy_d      = state_d != IDLE;
  end

  assign req_ready_o = req_ready_q;
  assign grant_id_o  = grant_id_q;
  assign tx_din_o    = tx_din_q;
  assign tx_start_o  = tx_start_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, directed corner sequences and a randomized
// run against a behavioural model of the round-robin arbiter (GAP_CYC=3, TIMEOUT_CYC=50).
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, GAP = 3, TO = 50;
  localparam logic [N*W-1:0] D = 32'h44A5_2211;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic tx_done_tick = 1'b0;
  logic [N-1:0] req_ready;
  logic [1:0] grant_id;
  logic busy, tx_start, timeout_err;
  logic [W-1:0] tx_din;
  int errs = 0, checks = 0;

  uart_tx_arbiter #(.NREQ(N), .DBIT(W), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .grant_id_o(grant_id), .busy_o(busy), .tx_start_o(tx_start),
    .tx_din_o(tx_din), .tx_done_tick_i(tx_done_tick), .timeout_err_o(timeout_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] v;
    logic dn;
    logic [N-1:0] ready;
    logic start;
    logic [W-1:0] din;
    int gid;
    logic bsy;
  } vec_t;
  vec_t tbl[14];

  // behavioural model: mode 0 idle, 1 waiting for frame end, 2 inter-frame gap
  int m_mode, m_gap, m_ptr, m_wcnt;
  logic [N-1:0] e_ready;
  logic e_start, e_busy, e_to;
  logic [W-1:0] e_din;
  int e_gid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge;
    logic was_start, dn;
    int g;
    was_start = e_start;
    e_ready = '0;
    e_start = 1'b0;
    e_to = 1'b0;
    g = -1;
    if (reset) begin
      m_mode = 0; m_ptr = 0; m_wcnt = 0; m_gap = 0;
      e_din = '0; e_gid = 0; e_busy = 1'b0;
    end else if (m_mode == 0) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        e_din = req_data[g*W +: W];
        e_gid = g;
        e_ready = N'(1) << g;
        e_start = 1'b1;
        e_busy = 1'b1;
        m_ptr = (g + 1) % N;
        m_mode = 1;
        m_wcnt = 0;
      end
    end else if (m_mode == 1) begin
      dn = tx_done_tick && !was_start;
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (!dn && m_wcnt == TO - 1) begin
        dn = 1'b1;
        e_to = 1'b1;
      end
      m_wcnt++;
`endif
      if (dn) begin
        if (GAP == 0) begin m_mode = 0; e_busy = 1'b0; end
        else begin m_mode = 2; m_gap = GAP; end
      end
    end else begin
      m_gap--;
      if (m_gap == 0) begin m_mode = 0; e_busy = 1'b0; end
    end
  endtask

  task automatic compare_all;
    chk("rnd.req_ready", req_ready, e_ready);
    chk("rnd.tx_start", tx_start, e_start);
    chk("rnd.tx_din", tx_din, e_din);
    chk("rnd.grant_id", grant_id, e_gid);
    chk("rnd.busy", busy, e_busy);
    chk("rnd.timeout_err", timeout_err, e_to);
  endtask

  task automatic cycle;
    model_edge();
    tick();
    compare_all();
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!tx_start && n < 40) begin
      tick();
      n++;
    end
    chk(name, tx_start, 1'b1);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0;
    tx_done_tick = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] pend;
    logic saw_to;
    int n;
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA5, 2, 1'b1};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2, 1'b1};
    tbl[2]  = '{4'b0011, 1'b0, 4'b0000, 1'b0, 8'hA5, 2, 1'b1};
    tbl[3]  = '{4'b0011, 1'b1, 4'b0000, 1'b0, 8'hA5, 2, 1'b1};
    tbl[4]  = '{4'b0011, 1'b1, 4'b0000, 1'b0, 8'hA5, 2, 1'b1};
    tbl[5]  = '{4'b0011, 1'b0, 4'b0000, 1'b0, 8'hA5, 2, 1'b1};
    tbl[6]  = '{4'b0011, 1'b0, 4'b0000, 1'b0, 8'hA5, 2, 1'b0};
    tbl[7]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 8'h11, 0, 1'b1};
    tbl[8]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 8'h11, 0, 1'b1};
    tbl[9]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 8'h11, 0, 1'b1};
    tbl[10] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 8'h11, 0, 1'b1};
    tbl[11] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 8'h11, 0, 1'b1};
    tbl[12] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 8'h11, 0, 1'b0};
    tbl[13] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'h22, 1, 1'b1};

    // reset held with random requests
    for (int c = 0; c < 3; c++) begin
      req_valid = N'($urandom);
      req_data = $urandom;
      tick();
      chk("rst.req_ready", req_ready, 0);
      chk("rst.tx_start", tx_start, 0);
      chk("rst.busy", busy, 0);
      chk("rst.tx_din", tx_din, 0);
      chk("rst.grant_id", grant_id, 0);
      chk("rst.timeout_err", timeout_err, 0);
    end
    reset = 1'b0;

    // single grant, ignored done tick in start cycle, gap timing, wrap-around
    req_data = D;
    foreach (tbl[r]) begin
      req_valid = tbl[r].v;
      tx_done_tick = tbl[r].dn;
      tick();
      chk($sformatf("row%0d.req_ready", r), req_ready, tbl[r].ready);
      chk($sformatf("row%0d.tx_start", r), tx_start, tbl[r].start);
      chk($sformatf("row%0d.tx_din", r), tx_din, tbl[r].din);
      chk($sformatf("row%0d.grant_id", r), grant_id, tbl[r].gid);
      chk($sformatf("row%0d.busy", r), busy, tbl[r].bsy);
      chk($sformatf("row%0d.timeout_err", r), timeout_err, 0);
    end

    // long frame: busy held until done tick, then falls GAP+1 cycles later
    do_reset();
    req_valid = 4'b0100;
    tick();
    chk("frame.grant_id", grant_id, 2);
    chk("frame.tx_din", tx_din, 8'hA5);
    req_valid = '0;
    repeat (19) tick();
    chk("frame.busy_mid", busy, 1);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    repeat (GAP - 1) tick();
    chk("frame.busy_gap", busy, 1);
    tick();
    chk("frame.busy_end", busy, 0);

    // all requesting: order 0,1,2,3,0 with one ready bit each
    do_reset();
    req_data = 32'hD3C2_B1A0;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start($sformatf("rr%0d.start_seen", i));
      chk($sformatf("rr%0d.grant_id", i), grant_id, i % N);
      chk($sformatf("rr%0d.tx_din", i), tx_din, req_data[(i%N)*W +: W]);
      chk($sformatf("rr%0d.req_ready", i), req_ready, N'(1) << (i % N));
      repeat (3) tick();
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
    end

    // stuck frame: watchdog or indefinite wait, then reset mid-WAIT
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
`ifdef UART_TX_ARB_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    chk("wd.latency", n, TO);
    chk("wd.busy", busy, 1);
    wait_start("wd.next_start");
    chk("wd.next_grant", grant_id, 1);
`else
    saw_to = 1'b0;
    repeat (300) begin
      tick();
      if (timeout_err) saw_to = 1'b1;
    end
    chk("stuck.busy", busy, 1);
    chk("stuck.timeout_err", saw_to, 0);
    chk("stuck.grant_id", grant_id, 0);
`endif
    reset = 1'b1;
    tick();
    chk("midrst.busy", busy, 0);
    chk("midrst.req_ready", req_ready, 0);
    chk("midrst.tx_start", tx_start, 0);
    reset = 1'b0;
    tick();
    chk("midrst.grant_id", grant_id, 1);
    chk("midrst.req_ready_after", req_ready, 4'b0010);

    // randomized producers and done ticks against the model
    pend = '0;
    reset = 1'b1;
    req_valid = '0;
    tx_done_tick = 1'b0;
    cycle();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end else if (pend[i] && $urandom_range(63) == 0) pend[i] = 1'b0;
      end
      req_valid = pend;
      tx_done_tick = ($urandom_range(5) == 0);
      reset = ($urandom_range(299) == 0);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
